// File: rtl/tree_msg_encoder.sv
// tree_msg_encoder: serialises a stream of field-write and nested-message
// open/close commands into a protobuf-style byte stream. Each VARINT or
// OPEN command emits a varint tag ({field_id, wire_type}) followed by a
// varint value (the field value, or the sub-message body length). A small
// stack of remaining-length counters checks that every opened sub-message
// receives exactly its declared number of body bytes.
module tree_msg_encoder #(
    parameter int DATA_W    = 32,
    parameter int MAX_DEPTH = 2,
    parameter int ID_W      = 5,
    localparam int DEP_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_cmd,
    input  logic [ID_W-1:0]   in_field_id,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [DEP_W-1:0]  depth,
    output logic              msg_done,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam logic [1:0] CMD_VARINT = 2'd0;
    localparam logic [1:0] CMD_OPEN   = 2'd1;
    localparam logic [1:0] CMD_CLOSE  = 2'd2;

    localparam logic [2:0] ERR_LEN_MISMATCH = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW     = 3'd2;
    localparam logic [2:0] ERR_UNDERFLOW    = 3'd3;
    localparam logic [2:0] ERR_OVERRUN      = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL      = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_VALUE} state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [7:0]          r_out_byte;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_tag_rem;   // tag bits not yet emitted
    logic [DATA_W-1:0]   r_val;       // value bits not yet emitted
    logic [DATA_W-1:0]   r_len;       // OPEN body length, pushed after the last length byte
    logic                r_is_open;
    logic [DEP_W-1:0]    r_depth;
    logic                r_msg_done;
    logic                r_err;
    logic [2:0]          r_err_code;

    logic                w_accept;
    logic                w_xfer;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_tag;
    logic [DATA_W-1:0]   w_top;
    logic                w_any_zero;
    logic                w_err_evt;
    logic [2:0]          w_err_code;
    logic [DATA_W-1:0]   w_cnt [MAX_DEPTH];

    // One varint byte: low 7 bits, continuation bit set if anything remains above them.
    function automatic logic [7:0] f_enc(input logic [DATA_W-1:0] v);
        return {(v[DATA_W-1:7] != '0), v[6:0]};
    endfunction

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = r_out_valid && out_ready;
    // The last length byte of an OPEN leaving the port opens the new level.
    assign w_push   = w_xfer && (r_state == S_VALUE) && r_out_last && r_is_open;
    assign w_pop    = w_accept && (in_cmd == CMD_CLOSE) && (r_depth != '0);
    // Wire type 2 (length-delimited) for OPEN, 0 (varint) otherwise.
    assign w_tag    = {{(DATA_W-ID_W-3){1'b0}}, in_field_id, 1'b0, (in_cmd == CMD_OPEN), 1'b0};

    // Select the innermost counter and flag any active level that is already exhausted.
    always_comb begin
        w_top      = '0;
        w_any_zero = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (r_depth == DEP_W'(i + 1)) begin
                w_top = w_cnt[i];
            end
            if ((DEP_W'(i) < r_depth) && (w_cnt[i] == '0)) begin
                w_any_zero = 1'b1;
            end
        end
    end

    // Classify the error (if any) raised this cycle; accepts and transfers never overlap.
    always_comb begin
        w_err_evt  = 1'b0;
        w_err_code = '0;
        if (w_accept) begin
            case (in_cmd)
                CMD_OPEN: begin
                    if (r_depth == DEP_W'(MAX_DEPTH)) begin
                        w_err_evt  = 1'b1;
                        w_err_code = ERR_OVERFLOW;
                    end
                end
                CMD_CLOSE: begin
                    if (r_depth == '0) begin
                        w_err_evt  = 1'b1;
                        w_err_code = ERR_UNDERFLOW;
                    end else if (w_top != '0) begin
                        w_err_evt  = 1'b1;
                        w_err_code = ERR_LEN_MISMATCH;
                    end
                end
                CMD_VARINT: ;
                default: begin
                    w_err_evt  = 1'b1;
                    w_err_code = ERR_ILLEGAL;
                end
            endcase
        end
        if (w_xfer && w_any_zero) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_OVERRUN;
        end
    end

    // Per-level remaining-length counters; level gi+1 is active while depth > gi.
    generate
        for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_lvl
            logic [DATA_W-1:0] r_cnt;

            // Load on push, clear on pop, count down (saturating) on every transferred byte.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_pop && (r_depth == DEP_W'(gi + 1))) begin
                    r_cnt <= '0;
                end else if (w_push && (r_depth == DEP_W'(gi))) begin
                    r_cnt <= r_len;
                end else if (w_xfer && (DEP_W'(gi) < r_depth) && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - DATA_W'(1);
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    // Command FSM: accept in IDLE, stream tag bytes, then value bytes, then return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_byte  <= '0;
            r_out_last  <= 1'b0;
            r_tag_rem   <= '0;
            r_val       <= '0;
            r_len       <= '0;
            r_is_open   <= 1'b0;
            r_depth     <= '0;
            r_msg_done  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_msg_done <= 1'b0;
            if (w_err_evt && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if ((in_cmd == CMD_VARINT) ||
                            ((in_cmd == CMD_OPEN) && (r_depth != DEP_W'(MAX_DEPTH)))) begin
                            r_out_byte  <= f_enc(w_tag);
                            r_tag_rem   <= w_tag >> 7;
                            r_val       <= in_value;
                            r_len       <= in_value;
                            r_is_open   <= (in_cmd == CMD_OPEN);
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b0;
                            r_state     <= S_TAG;
                        end else if (w_pop) begin
                            r_depth <= r_depth - DEP_W'(1);
                            if (r_depth == DEP_W'(1)) begin
                                r_msg_done <= 1'b1;
                            end
                        end
                    end
                end
                S_TAG: begin
                    if (w_xfer) begin
                        if (r_tag_rem != '0) begin
                            r_out_byte <= f_enc(r_tag_rem);
                            r_tag_rem  <= r_tag_rem >> 7;
                        end else begin
                            r_out_byte <= f_enc(r_val);
                            r_out_last <= (r_val[DATA_W-1:7] == '0);
                            r_val      <= r_val >> 7;
                            r_state    <= S_VALUE;
                        end
                    end
                end
                S_VALUE: begin
                    if (w_xfer) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                            if (r_is_open) begin
                                r_depth <= r_depth + DEP_W'(1);
                            end
                        end else begin
                            r_out_byte <= f_enc(r_val);
                            r_out_last <= (r_val[DATA_W-1:7] == '0);
                            r_val      <= r_val >> 7;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;
    assign depth     = r_depth;
    assign msg_done  = r_msg_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_tree_msg_encoder.sv
// Testbench for tree_msg_encoder: directed cases with literal byte
// expectations plus randomised command streams checked against a
// byte-list / length-stack reference model.
module tb_tree_msg_encoder;

    localparam int DATA_W    = 32;
    localparam int MAX_DEPTH = 2;
    localparam int ID_W      = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_cmd = '0;
    logic [ID_W-1:0]   in_field_id = '0;
    logic [DATA_W-1:0] in_value = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_byte;
    logic              out_last;
    logic [1:0]        depth;
    logic              msg_done;
    logic              err;
    logic [2:0]        err_code;

    always #5 clk = ~clk;

    tree_msg_encoder #(.DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_field_id(in_field_id),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .depth      (depth),
        .msg_done   (msg_done),
        .err        (err),
        .err_code   (err_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Expected and observed byte streams: {last, byte}
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    // Reference model state
    int      m_depth;
    longint  m_cnt [MAX_DEPTH+1];
    bit      m_err;
    int      m_code;

    // Output sink control: 0 random ready, 1 fixed pattern, 2 always ready
    int   rdy_mode = 2;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   pat_idx = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_byte;
    logic prev_last;

    // Output monitor: choose out_ready for the coming edge and check each transferred byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", out_valid, 1);
                check_val("stall_byte", out_byte, prev_byte);
                check_val("stall_last", out_last, prev_last);
            end
            case (rdy_mode)
                0: out_ready = ($urandom_range(0, 3) != 0);
                1: if (out_valid) begin
                       out_ready = (pat_idx < 6) ? pat[pat_idx] : 1'b1;
                       pat_idx++;
                   end
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                obs_q.push_back({out_last, out_byte});
                if (exp_q.size() == 0) begin
                    check_val("extra_byte", {out_last, out_byte}, 9'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check_val("byte", out_byte, e[7:0]);
                    check_val("last", out_last, e[8]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            prev_last  = out_last;
        end
    end

    task automatic m_clear();
        m_depth = 0;
        m_err   = 0;
        m_code  = 0;
        for (int i = 0; i <= MAX_DEPTH; i++) m_cnt[i] = 0;
        exp_q.delete();
    endtask

    task automatic m_set_err(input int c);
        if (!m_err) begin
            m_err  = 1;
            m_code = c;
        end
    endtask

    // Every emitted byte is charged to all currently open levels.
    task automatic m_account(input int n);
        for (int k = 0; k < n; k++)
            for (int l = 1; l <= m_depth; l++)
                if (m_cnt[l] == 0) m_set_err(4);
                else m_cnt[l]--;
    endtask

    task automatic emit(input longint unsigned v, input bit is_val, inout int nb);
        longint unsigned x;
        logic [7:0] b;
        x = v;
        do begin
            b = 8'(x % 128);
            x = x / 128;
            if (x != 0) b = b + 8'd128;
            exp_q.push_back({(is_val && x == 0), b});
            nb++;
        end while (x != 0);
    endtask

    function automatic int varint_len(input longint unsigned v);
        int n = 0;
        longint unsigned x = v;
        do begin
            x = x / 128;
            n++;
        end while (x != 0);
        return n;
    endfunction

    // Apply one command to the reference model; returns bytes expected and msg_done expectation.
    task automatic model_cmd(input logic [1:0] cmd, input logic [4:0] id, input logic [31:0] val,
                             output int nb, output bit done_exp);
        nb = 0;
        done_exp = 0;
        case (cmd)
            2'd0: begin
                emit(longint'(id) * 8, 0, nb);
                emit(longint'(val), 1, nb);
                m_account(nb);
            end
            2'd1: begin
                if (m_depth == MAX_DEPTH) m_set_err(2);
                else begin
                    emit(longint'(id) * 8 + 2, 0, nb);
                    emit(longint'(val), 1, nb);
                    m_account(nb);
                    m_depth++;
                    m_cnt[m_depth] = longint'(val);
                end
            end
            2'd2: begin
                if (m_depth == 0) m_set_err(3);
                else begin
                    if (m_cnt[m_depth] != 0) m_set_err(1);
                    m_cnt[m_depth] = 0;
                    m_depth--;
                    done_exp = (m_depth == 0);
                end
            end
            default: m_set_err(5);
        endcase
    endtask

    task automatic send(input logic [1:0] cmd, input logic [4:0] id, input logic [31:0] val);
        int nb, t;
        bit done_exp;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_val("ready_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_cmd = cmd;
        in_field_id = id;
        in_value = val;
        model_cmd(cmd, id, val, nb, done_exp);
        @(negedge clk);
        in_valid = 1'b0;
        in_cmd = 2'($urandom);
        in_field_id = 5'($urandom);
        in_value = $urandom;
        check_val("msg_done", msg_done, done_exp);
        check_val("first_byte_latency", out_valid, (nb > 0));
        t = 0;
        while ((out_valid || exp_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            check_val("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        if (done_exp) begin
            @(negedge clk);
            check_val("msg_done_pulse", msg_done, 0);
        end
        check_val("depth", depth, m_depth);
        check_val("err", err, m_err);
        check_val("err_code", err_code, m_code);
        check_val("in_ready_idle", in_ready, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_byte", out_byte, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_depth", depth, 0);
        check_val("rst_msg_done", msg_done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_err_code", err_code, 0);
        m_clear();
        rst_n = 1'b1;
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [8:0] exp);
        if (obs_q.size() > idx) check_val(tag, obs_q[idx], exp);
        else check_val(tag, 9'h1ff, exp);
    endtask

    initial begin
        int nb, t, r, len;
        bit done_exp;
        logic [4:0]  id;
        logic [31:0] v;

        // VARINT id=1 value=150 and id=31 value=0
        rdy_mode = 2;
        do_reset();
        obs_q.delete();
        send(2'd0, 5'd1, 32'd150);
        check_val("t1_count", obs_q.size(), 3);
        check_obs("t1_b0", 0, 9'h008);
        check_obs("t1_b1", 1, 9'h096);
        check_obs("t1_b2", 2, 9'h101);
        obs_q.delete();
        send(2'd0, 5'd31, 32'd0);
        check_obs("t2_b0", 0, 9'h0F8);
        check_obs("t2_b1", 1, 9'h001);
        check_obs("t2_b2", 2, 9'h100);
        check_val("t2_err", err, 0);

        // Nested message with exact length
        do_reset();
        obs_q.delete();
        send(2'd1, 5'd1, 32'd2);
        check_val("t3_depth1", depth, 1);
        send(2'd0, 5'd4, 32'd5);
        send(2'd2, 5'd0, 32'd0);
        check_val("t3_depth0", depth, 0);
        check_val("t3_err", err, 0);
        check_obs("t3_b0", 0, 9'h00A);
        check_obs("t3_b1", 1, 9'h102);
        check_obs("t3_b2", 2, 9'h020);
        check_obs("t3_b3", 3, 9'h105);

        // Backpressure pattern 1,0,0,1,0,1
        do_reset();
        obs_q.delete();
        rdy_mode = 1;
        pat_idx = 0;
        send(2'd0, 5'd1, 32'd150);
        rdy_mode = 2;
        check_val("bp_count", obs_q.size(), 3);
        check_obs("bp_b0", 0, 9'h008);
        check_obs("bp_b1", 1, 9'h096);
        check_obs("bp_b2", 2, 9'h101);

        // Length mismatch
        do_reset();
        send(2'd1, 5'd1, 32'd3);
        send(2'd0, 5'd4, 32'd5);
        send(2'd2, 5'd0, 32'd0);
        check_val("lm_err", err, 1);
        check_val("lm_code", err_code, 1);
        check_val("lm_depth", depth, 0);

        // Overflow
        do_reset();
        send(2'd1, 5'd1, 32'd5);
        send(2'd1, 5'd2, 32'd5);
        send(2'd1, 5'd3, 32'd5);
        check_val("ov_code", err_code, 2);
        check_val("ov_depth", depth, 2);

        // Underflow
        do_reset();
        send(2'd2, 5'd0, 32'd0);
        check_val("uf_code", err_code, 3);

        // Reset after the second byte of an encoding
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd = 2'd0;
        in_field_id = 5'd1;
        in_value = 32'd150;
        model_cmd(2'd0, 5'd1, 32'd150, nb, done_exp);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (exp_q.size() != 1 && t < 20);
        check_val("mr_reached_byte2", exp_q.size(), 1);
        rst_n = 1'b0;
        #1;
        check_val("mr_out_valid", out_valid, 0);
        check_val("mr_in_ready", in_ready, 1);
        check_val("mr_depth", depth, 0);
        m_clear();
        @(negedge clk);
        @(negedge clk);
        check_val("mr_no_more_bytes", out_valid, 0);
        rst_n = 1'b1;
        obs_q.delete();
        send(2'd0, 5'd1, 32'd150);
        check_obs("mr_b0", 0, 9'h008);
        check_obs("mr_b1", 1, 9'h096);
        check_obs("mr_b2", 2, 9'h101);

        // Randomised command streams
        for (int round = 0; round < 8; round++) begin
            rdy_mode = 2;
            do_reset();
            rdy_mode = 0;
            for (int k = 0; k < 25; k++) begin
                r  = $urandom_range(0, 19);
                id = 5'($urandom);
                v  = $urandom >> $urandom_range(0, 31);
                if (r < 8) send(2'd0, id, v);
                else if (r < 11) send(2'd1, id, 32'($urandom_range(0, 8)));
                else if (r < 15) send(2'd2, id, v);
                else if (r == 15) send(2'd3, id, v);
                else begin
                    len = varint_len(longint'(id) * 8) + varint_len(longint'(v));
                    send(2'd1, 5'($urandom), 32'(len));
                    send(2'd0, id, v);
                    send(2'd2, 5'd0, 32'd0);
                end
            end
        end
        rdy_mode = 2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
